// File: rtl/riscv_hazard_unit_if.sv
// Hazard-unit bundle: ID-stage decode fields in, pipeline-register control out.
// Optional HAZARD_WB_BYPASS_EN adds the ID-stage WB bypass flags.
interface riscv_hazard_unit_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              hold;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_is_load;
    logic              ex_branch_taken;

    logic              stall_if_id;
    logic              bubble_ex;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt;
`ifdef HAZARD_WB_BYPASS_EN
    logic              id_wb_fwd_rs1;
    logic              id_wb_fwd_rs2;
`endif

    // Pipeline / decode side.
    modport master (
`ifdef HAZARD_WB_BYPASS_EN
        input  id_wb_fwd_rs1, id_wb_fwd_rs2,
`endif
        output hold, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output id_rd, id_reg_write, id_is_load, ex_branch_taken,
        input  stall_if_id, bubble_ex, flush_if_id, flush_id_ex,
        input  fwd_a_sel, fwd_b_sel, stall_cnt
    );

    // Hazard unit side.
    modport slave (
`ifdef HAZARD_WB_BYPASS_EN
        output id_wb_fwd_rs1, id_wb_fwd_rs2,
`endif
        input  hold, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  id_rd, id_reg_write, id_is_load, ex_branch_taken,
        output stall_if_id, bubble_ex, flush_if_id, flush_id_ex,
        output fwd_a_sel, fwd_b_sel, stall_cnt
    );
endinterface

// File: rtl/riscv_hazard_unit.sv
// Hazard controller for the five-stage RISCVCPU pipeline.
// Tracks destination registers in EX/MEM/WB, registers EX operand bypass
// selects one cycle ahead, detects load-use hazards and sequences branch flushes.
// Optional feature: define HAZARD_WB_BYPASS_EN to drive id_wb_fwd_rs1/rs2.
module riscv_hazard_unit #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    riscv_hazard_unit_if.slave   bus
);

    localparam logic [1:0] SelRf  = 2'b00;
    localparam logic [1:0] SelWb  = 2'b01;
    localparam logic [1:0] SelMem = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              is_load;
    } slot_t;

    slot_t            ex_q, ex_d;
    slot_t            mem_q, mem_d;
    slot_t            wb_q, wb_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ex_wr, mem_wr, wb_wr;
    logic hit_ex_rs1, hit_ex_rs2, hit_mem_rs1, hit_mem_rs2;
    logic hazard, stall, flush, id_enter;
    logic [1:0] sel_a, sel_b;

    // A slot only matters for bypass/hazards when it really writes a non-x0 register.
    function automatic logic slot_writes(slot_t s);
        return s.valid & s.reg_write & (s.rd != '0);
    endfunction

    // Match ID source operands against the shadow slots and derive control.
    always_comb begin
        ex_wr  = slot_writes(ex_q);
        mem_wr = slot_writes(mem_q);
        wb_wr  = slot_writes(wb_q);

        hit_ex_rs1  = bus.id_uses_rs1 & ex_wr  & (bus.id_rs1 == ex_q.rd);
        hit_ex_rs2  = bus.id_uses_rs2 & ex_wr  & (bus.id_rs2 == ex_q.rd);
        hit_mem_rs1 = bus.id_uses_rs1 & mem_wr & (bus.id_rs1 == mem_q.rd);
        hit_mem_rs2 = bus.id_uses_rs2 & mem_wr & (bus.id_rs2 == mem_q.rd);

        hazard = ex_q.is_load & bus.id_valid & (hit_ex_rs1 | hit_ex_rs2);

        // reset_n gating keeps the outputs quiet while reset is held.
        stall    = hazard & ~bus.ex_branch_taken & ~bus.hold & reset_n;
        flush    = bus.ex_branch_taken & ~bus.hold & reset_n;
        id_enter = bus.id_valid & ~stall & ~flush;

        // Younger producer (EX slot) wins; it sits in EX/MEM when the consumer is in EX.
        sel_a = SelRf;
        if (hit_ex_rs1) begin
            sel_a = SelMem;
        end else if (hit_mem_rs1) begin
            sel_a = SelWb;
        end
        sel_b = SelRf;
        if (hit_ex_rs2) begin
            sel_b = SelMem;
        end else if (hit_mem_rs2) begin
            sel_b = SelWb;
        end
    end

    // Next-state: advance the shadow unless the pipeline is frozen.
    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        cnt_d   = cnt_q;
        if (!bus.hold) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (id_enter) begin
                ex_d    = '{valid: 1'b1, rd: bus.id_rd, reg_write: bus.id_reg_write,
                            is_load: bus.id_is_load};
                fwd_a_d = sel_a;
                fwd_b_d = sel_b;
            end else begin
                ex_d    = '0;
                fwd_a_d = SelRf;
                fwd_b_d = SelRf;
            end
            if (stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= SelRf;
            fwd_b_q <= SelRf;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall_if_id = stall;
    assign bus.bubble_ex   = stall;
    assign bus.flush_if_id = flush;
    assign bus.flush_id_ex = flush;
    assign bus.fwd_a_sel   = fwd_a_q;
    assign bus.fwd_b_sel   = fwd_b_q;
    assign bus.stall_cnt   = cnt_q;

`ifdef HAZARD_WB_BYPASS_EN
    // Flag an operand whose only live producer is in WB, so ID can bypass the stale read.
    always_comb begin
        bus.id_wb_fwd_rs1 = bus.id_uses_rs1 & wb_wr & (bus.id_rs1 == wb_q.rd) &
                            ~hit_ex_rs1 & ~hit_mem_rs1;
        bus.id_wb_fwd_rs2 = bus.id_uses_rs2 & wb_wr & (bus.id_rs2 == wb_q.rd) &
                            ~hit_ex_rs2 & ~hit_mem_rs2;
    end
`endif

    // Load flags past EX and (without WB bypass) the whole WB slot are bookkeeping only.
    logic unused_shadow;
    assign unused_shadow = ^{mem_q.is_load, wb_q, wb_wr};

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Self-checking bench for riscv_hazard_unit: a scripted instruction stream with
// hand-derived expected control values queued per cycle and compared after settling.
module tb_riscv_hazard_unit;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    riscv_hazard_unit_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

    riscv_hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        bit          v;
        bit [AW-1:0] rs1;
        bit          u1;
        bit [AW-1:0] rs2;
        bit          u2;
        bit [AW-1:0] rd;
        bit          rw;
        bit          ld;
    } instr_t;

    typedef struct packed {
        int unsigned step;
        bit          stall;
        bit          flush;
        bit [1:0]    fa;
        bit [1:0]    fb;
        bit [CW-1:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned step_no  = 0;

    function automatic instr_t alu(int rd, int rs1, int rs2);
        return '{v: 1'b1, rs1: AW'(rs1), u1: 1'b1, rs2: AW'(rs2), u2: 1'b1,
                 rd: AW'(rd), rw: 1'b1, ld: 1'b0};
    endfunction

    function automatic instr_t addi(int rd, int rs1);
        return '{v: 1'b1, rs1: AW'(rs1), u1: 1'b1, rs2: '0, u2: 1'b0,
                 rd: AW'(rd), rw: 1'b1, ld: 1'b0};
    endfunction

    function automatic instr_t lw(int rd, int rs1);
        return '{v: 1'b1, rs1: AW'(rs1), u1: 1'b1, rs2: '0, u2: 1'b0,
                 rd: AW'(rd), rw: 1'b1, ld: 1'b1};
    endfunction

    function automatic instr_t nop();
        return '0;
    endfunction

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input instr_t ins, input bit br, input bit hd);
        bus.id_valid        = ins.v;
        bus.id_rs1          = ins.rs1;
        bus.id_uses_rs1     = ins.u1;
        bus.id_rs2          = ins.rs2;
        bus.id_uses_rs2     = ins.u2;
        bus.id_rd           = ins.rd;
        bus.id_reg_write    = ins.rw;
        bus.id_is_load      = ins.ld;
        bus.ex_branch_taken = br;
        bus.hold            = hd;
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        check_eq($sformatf("s%0d_stall_if_id", e.step), 32'(bus.stall_if_id), 32'(e.stall));
        check_eq($sformatf("s%0d_bubble_ex", e.step), 32'(bus.bubble_ex), 32'(e.stall));
        check_eq($sformatf("s%0d_flush_if_id", e.step), 32'(bus.flush_if_id), 32'(e.flush));
        check_eq($sformatf("s%0d_flush_id_ex", e.step), 32'(bus.flush_id_ex), 32'(e.flush));
        check_eq($sformatf("s%0d_fwd_a_sel", e.step), 32'(bus.fwd_a_sel), 32'(e.fa));
        check_eq($sformatf("s%0d_fwd_b_sel", e.step), 32'(bus.fwd_b_sel), 32'(e.fb));
        check_eq($sformatf("s%0d_stall_cnt", e.step), 32'(bus.stall_cnt), 32'(e.cnt));
    endtask

    // One ID cycle: drive on the falling edge, queue expectations, sample before the rise.
    task automatic step(input instr_t ins, input bit br, input bit hd, input bit es,
                        input bit ef, input bit [1:0] fa, input bit [1:0] fb,
                        input int unsigned cnt);
        @(negedge clock);
        step_no++;
        drive(ins, br, hd);
        sb.push_back('{step: step_no, stall: es, flush: ef, fa: fa, fb: fb, cnt: CW'(cnt)});
        #2;
        compare_front();
    endtask

    initial begin
        // Reset: everything quiet even with a branch request present.
        drive(alu(6, 5, 1), 1'b1, 1'b0);
        #2;
        check_eq("rst_stall", 32'(bus.stall_if_id), 0);
        check_eq("rst_flush", 32'(bus.flush_if_id), 0);
        check_eq("rst_fwd_a", 32'(bus.fwd_a_sel), 0);
        check_eq("rst_fwd_b", 32'(bus.fwd_b_sel), 0);
        check_eq("rst_cnt", 32'(bus.stall_cnt), 0);
        @(negedge clock);
        drive(nop(), 1'b0, 1'b0);
        reset_n = 1'b1;

        // Bypass selects: MEM -> 01, EX -> 10, EX beats MEM, x0 never forwards.
        step(addi(1, 0),   0, 0, 0, 0, 2'b00, 2'b00, 0);
        step(addi(2, 0),   0, 0, 0, 0, 2'b00, 2'b00, 0);
        step(alu(3, 1, 2), 0, 0, 0, 0, 2'b00, 2'b00, 0);
        step(alu(4, 3, 2), 0, 0, 0, 0, 2'b01, 2'b10, 0);
        step(alu(4, 4, 3), 0, 0, 0, 0, 2'b10, 2'b01, 0);
        step(alu(9, 4, 4), 0, 0, 0, 0, 2'b10, 2'b01, 0);
        step(addi(0, 0),   0, 0, 0, 0, 2'b10, 2'b10, 0);
        step(alu(7, 0, 0), 0, 0, 0, 0, 2'b00, 2'b00, 0);
        step(lw(0, 1),     0, 0, 0, 0, 2'b00, 2'b00, 0);
        step(alu(8, 0, 1), 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Load-use: one stall cycle, consumer then gets 01.
        step(lw(5, 1),     0, 0, 0, 0, 2'b00, 2'b00, 0);
        step(alu(6, 5, 1), 0, 0, 1, 0, 2'b00, 2'b00, 0);
        step(alu(6, 5, 1), 0, 0, 0, 0, 2'b00, 2'b00, 1);
        step(nop(),        0, 0, 0, 0, 2'b01, 2'b00, 1);

        // Branch overrides the stall; the squashed ID leaves a bubble in EX.
        step(lw(5, 1),     0, 0, 0, 0, 2'b00, 2'b00, 1);
        step(alu(6, 5, 1), 1, 0, 0, 1, 2'b00, 2'b00, 1);
        step(alu(6, 5, 1), 0, 0, 0, 0, 2'b00, 2'b00, 1);
        step(nop(),        0, 0, 0, 0, 2'b01, 2'b00, 1);

        // Hold during a load-use hazard freezes everything and masks control.
        step(lw(5, 6),     0, 0, 0, 0, 2'b00, 2'b00, 1);
        step(alu(6, 5, 1), 0, 1, 0, 0, 2'b01, 2'b00, 1);
        step(alu(6, 5, 1), 1, 1, 0, 0, 2'b01, 2'b00, 1);
        step(alu(6, 5, 1), 0, 1, 0, 0, 2'b01, 2'b00, 1);
        step(alu(6, 5, 1), 0, 0, 1, 0, 2'b01, 2'b00, 1);
        step(alu(6, 5, 1), 0, 0, 0, 0, 2'b00, 2'b00, 2);
        step(nop(),        0, 0, 0, 0, 2'b01, 2'b00, 2);

        // Reset in the middle of a stall clears state at once.
        step(lw(5, 0),     0, 0, 0, 0, 2'b00, 2'b00, 2);
        step(alu(6, 5, 1), 0, 0, 1, 0, 2'b00, 2'b00, 2);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_stall", 32'(bus.stall_if_id), 0);
        check_eq("midrst_bubble", 32'(bus.bubble_ex), 0);
        check_eq("midrst_cnt", 32'(bus.stall_cnt), 0);
        bus.ex_branch_taken = 1'b1;
        #1;
        check_eq("midrst_flush", 32'(bus.flush_id_ex), 0);
        @(negedge clock);
        bus.ex_branch_taken = 1'b0;
        reset_n = 1'b1;
        step(alu(6, 5, 1), 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Counter saturation with a narrow counter.
        for (int i = 0; i < 9; i++) begin
            step(lw(5, 0),   0, 0, 0, 0, (i == 0) ? 2'b00 : 2'b01, 2'b00, (i > 7) ? 7 : i);
            step(addi(6, 5), 0, 0, 1, 0, 2'b00, 2'b00, (i > 7) ? 7 : i);
            step(addi(6, 5), 0, 0, 0, 0, 2'b00, 2'b00, (i + 1 > 7) ? 7 : i + 1);
        end

        check_eq("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
